// File: rtl/lut_config_loader_pkg.sv
// Shared definitions for the CLB configuration loader.
//   cfg_load_state_t : loader FSM states (IDLE, SHIFT, COMMIT, DONE)
//   PARITY_BITS      : 1 when LUT_CONFIG_LOADER_PARITY_EN is defined, else 0
//   FRAME_LEN        : serial frame length for the default LUT size
//   BIT_COUNT_W      : bit_count width for the default LUT size
//   frame_len()/count_width() : same derivations for any MEM_SIZE
// Optional feature macro: LUT_CONFIG_LOADER_PARITY_EN (trailing even-parity bit).
package clb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } cfg_load_state_t;

`ifdef LUT_CONFIG_LOADER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int DEFAULT_ADDR_BITS = 4;
    localparam int DEFAULT_MEM_SIZE  = 2 ** DEFAULT_ADDR_BITS;
    localparam int FRAME_LEN         = DEFAULT_MEM_SIZE + PARITY_BITS;
    localparam int BIT_COUNT_W       = $clog2(DEFAULT_MEM_SIZE + 1);

    function automatic int frame_len(input int mem_size);
        return mem_size + PARITY_BITS;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lut_config_loader_shift_reg.sv
// Serial-in shift register holding the frame under assembly.
//   clk   : configuration clock
//   rst_n : synchronous active-low reset (clears contents)
//   en    : shift din into bit 0 this edge
//   din   : serial data bit
//   data  : register contents; first bit shifted in ends at data[WIDTH-1]
module cfg_shift_reg
    import clb_cfg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_MEM_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            data <= '0;
        else if (en)
            data <= {data[WIDTH-2:0], din};
    end

endmodule

// File: rtl/lut_config_loader.sv
// Serial-to-parallel configuration loader for one SLICEM LUT latch block.
// Assembles a frame from a bit-serial stream, then presents it on config_out
// with a COMMIT_CYCLES-long cen window, followed by a one-cycle done pulse.
//   cclk, rst_n         : config clock, synchronous active-low reset
//   cfg_bit, cfg_valid  : serial input, accepted when cfg_valid & cfg_ready
//   cfg_ready           : high in IDLE/SHIFT (decoded from state)
//   clr_err             : clears sticky overrun / parity_err
//   config_out, cen     : frame and commit enable to the latch block
//   done                : one-cycle pulse after a commit
//   bit_count           : bits received in the current frame
//   overrun, parity_err : sticky error flags
// Optional feature macro: LUT_CONFIG_LOADER_PARITY_EN adds a trailing even-parity
// bit to each frame; bad frames are discarded without a commit.
module lut_config_loader
    import clb_cfg_pkg::*;
#(
    parameter int ADDR_BITS     = 4,
    parameter int MEM_SIZE      = 2 ** ADDR_BITS,
    parameter int COMMIT_CYCLES = 2
) (
    input  logic                         cclk,
    input  logic                         rst_n,
    input  logic                         cfg_bit,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         clr_err,
    output logic [MEM_SIZE-1:0]          config_out,
    output logic                         cen,
    output logic                         done,
    output logic [$clog2(MEM_SIZE+1)-1:0] bit_count,
    output logic                         overrun,
    output logic                         parity_err
);

    localparam int FLEN  = frame_len(MEM_SIZE);
    localparam int CNT_W = count_width(FLEN);
    localparam int BC_W  = $clog2(MEM_SIZE + 1);
    localparam int CC_W  = 4;

    cfg_load_state_t      state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [CC_W-1:0]      ccnt;
    logic [MEM_SIZE-1:0]  shreg;
    logic [MEM_SIZE-1:0]  frame_nx;
    logic                 accept;
    logic                 last_bit;
    logic                 shift_en;
    logic                 par_bad;

    assign cfg_ready = (state == IDLE) || (state == SHIFT);
    assign accept    = cfg_valid & cfg_ready;
    assign last_bit  = accept && (cnt == CNT_W'(FLEN - 1));
    // Only data bits enter the shift register; a trailing parity bit does not.
    assign shift_en  = accept && (cnt < CNT_W'(MEM_SIZE));

    // Frame as it will look after this edge: on the final data bit the shift
    // register has not captured it yet, so fold it in here.
    assign frame_nx  = shift_en ? {shreg[MEM_SIZE-2:0], cfg_bit} : shreg;

    cfg_shift_reg #(.WIDTH(MEM_SIZE)) u_shift (
        .clk   (cclk),
        .rst_n (rst_n),
        .en    (shift_en),
        .din   (cfg_bit),
        .data  (shreg)
    );

`ifdef LUT_CONFIG_LOADER_PARITY_EN
    logic par_acc;

    // Running XOR of the frame so far; a correct frame XORs to 0 overall.
    assign par_bad = par_acc ^ cfg_bit;

    always_ff @(posedge cclk) begin
        if (!rst_n)
            par_acc <= 1'b0;
        else if (last_bit)
            par_acc <= 1'b0;
        else if (accept)
            par_acc <= par_acc ^ cfg_bit;
    end

    always_ff @(posedge cclk) begin
        if (!rst_n)
            parity_err <= 1'b0;
        else if (last_bit && par_bad)
            parity_err <= 1'b1;
        else if (clr_err)
            parity_err <= 1'b0;
    end
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge cclk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, SHIFT: begin
                if (last_bit)
                    state_nx = par_bad ? IDLE : COMMIT;
                else if (accept)
                    state_nx = SHIFT;
            end
            COMMIT:  if (ccnt == CC_W'(COMMIT_CYCLES - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cen/done are registered copies of the upcoming state so they line up
    // exactly with the COMMIT and DONE cycles.
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            cnt        <= '0;
            ccnt       <= '0;
            config_out <= '0;
            cen        <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cen  <= (state_nx == COMMIT);
            done <= (state_nx == DONE);

            if (state_nx == COMMIT && state != COMMIT)
                config_out <= frame_nx;

            if (state == COMMIT)
                ccnt <= ccnt + 1'b1;
            else
                ccnt <= '0;

            // Count holds at the frame length through COMMIT, clears in DONE.
            if (state_nx == IDLE || state_nx == DONE)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + 1'b1;

            if (cfg_valid && !cfg_ready)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end

    assign bit_count = BC_W'(cnt);

endmodule

// File: tb/tb_lut_config_loader.sv
// Randomized, scoreboarded bench for lut_config_loader (MEM_SIZE=16, COMMIT_CYCLES=2).
// Honours LUT_CONFIG_LOADER_PARITY_EN in the same way as the design.
module tb_lut_config_loader;

    localparam int MEM = 16;
    localparam int CC  = 2;
`ifdef LUT_CONFIG_LOADER_PARITY_EN
    localparam int FLEN = MEM + 1;
    localparam bit PAR  = 1'b1;
`else
    localparam int FLEN = MEM;
    localparam bit PAR  = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_bit = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            clr_err = 1'b0;
    logic            cfg_ready, cen, done, overrun, parity_err;
    logic [MEM-1:0]  config_out;
    logic [4:0]      bit_count;

    lut_config_loader #(.ADDR_BITS(4), .MEM_SIZE(MEM), .COMMIT_CYCLES(CC)) dut (
        .cclk       (clk),
        .rst_n      (rst_n),
        .cfg_bit    (cfg_bit),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .clr_err    (clr_err),
        .config_out (config_out),
        .cen        (cen),
        .done       (done),
        .bit_count  (bit_count),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: busy counts the cycles the loader is unavailable after
    // a committed frame (COMMIT_CYCLES of cen, then one done cycle).
    int          busy = 0;
    bit          bits[$];
    bit          m_ovr = 1'b0;
    bit          m_perr = 1'b0;
    logic [15:0] m_frame = '0;
    logic [15:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, busy == 0});
        chk("cen", {31'd0, cen}, {31'd0, busy > 1});
        chk("done", {31'd0, done}, {31'd0, busy == 1});
        if (busy == 0)
            chk("bit_count", {27'd0, bit_count}, bits.size());
        else if (busy == 1)
            chk("bit_count_done", {27'd0, bit_count}, 32'd0);
        chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
        chk("config_out", {16'd0, config_out}, {16'd0, m_frame});
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr, input bit rst);
        bit ovr_ev, perr_ev;
        logic [15:0] f;
        int ones;
        if (!rst) begin
            busy = 0; bits.delete(); m_ovr = 0; m_perr = 0; m_frame = '0;
            return;
        end
        ovr_ev = v && (busy > 0);
        perr_ev = 1'b0;
        if (busy > 0) begin
            busy--;
        end else if (v) begin
            bits.push_back(b);
            if (bits.size() == FLEN) begin
                f = '0; ones = 0;
                for (int i = 0; i < MEM; i++) f = {f[14:0], bits[i]};
                for (int i = 0; i < FLEN; i++) ones += int'(bits[i]);
                if (PAR && (ones % 2 != 0)) begin
                    perr_ev = 1'b1;
                end else begin
                    m_frame = f;
                    sb.push_back(f);
                    busy = CC + 1;
                end
                bits.delete();
            end
        end
        m_ovr  = ovr_ev  ? 1'b1 : (clr ? 1'b0 : m_ovr);
        m_perr = perr_ev ? 1'b1 : (clr ? 1'b0 : m_perr);
    endtask

    // One clock: check what the DUT shows now, drive, then advance the model.
    task automatic cycle(input bit v, input bit b, input bit clr, input bit rst);
        @(negedge clk);
        check_outputs();
        cfg_valid = v; cfg_bit = b; clr_err = clr; rst_n = rst;
        @(posedge clk);
        model_step(v, b, clr, rst);
    endtask

    task automatic idle_until_ready();
        int n = 0;
        while (busy > 0 && n < 10) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
            n++;
        end
    endtask

    task automatic send_frame(input logic [15:0] data, input bit corrupt, input bit gaps);
        bit fb[$];
        bit p;
        bit v, acc;
        int tries;
        p = ^data ^ corrupt;
        for (int i = MEM - 1; i >= 0; i--) fb.push_back(data[i]);
        if (PAR) fb.push_back(p);
        idle_until_ready();
        foreach (fb[k]) begin
            tries = 0;
            acc = 1'b0;
            while (!acc) begin
                v = gaps ? (($urandom_range(0, 2) != 0) || tries >= 4) : 1'b1;
                acc = v && (busy == 0);
                cycle(v, v ? fb[k] : 1'($urandom_range(0, 1)), 1'b0, 1'b1);
                tries++;
                if (tries > 20) begin
                    chk("send_timeout", 32'd1, 32'd0);
                    acc = 1'b1;
                end
            end
        end
    endtask

    // Scoreboard monitor: each rising cen pops the expected frame.
    logic        cen_q = 1'b0;
    logic [15:0] sb_exp;
    always @(negedge clk) begin
        if (cen && !cen_q) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_commit: cen rose with no frame expected, config_out %0h at %0t", config_out, $time);
            end else begin
                sb_exp = sb.pop_front();
                if (config_out !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_commit: config_out %0h expected %0h at %0t", config_out, sb_exp, $time);
                end
            end
        end
        cen_q = cen;
    end

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Basic load, valid held high
        send_frame(16'hA5C3, 1'b0, 1'b0);
        idle_until_ready();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Gapped input
        send_frame(16'h0001, 1'b0, 1'b1);
        idle_until_ready();

        // Overrun: keep valid high through COMMIT/DONE, then a clean frame
        send_frame(16'h3C96, 1'b0, 1'b0);
        for (int i = 0; i < CC + 1; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        send_frame(16'h1234, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);   // clr_err with a simultaneous overrun
        idle_until_ready();
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset after 8 bits
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(16'hFFFF, 1'b0, 1'b0);
        idle_until_ready();

        // Reset during the cen window
        send_frame(16'h5A5A, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(16'hFFFF, 1'b0, 1'b0);
        idle_until_ready();

`ifdef LUT_CONFIG_LOADER_PARITY_EN
        send_frame(16'h00FF, 1'b0, 1'b0);
        idle_until_ready();
        send_frame(16'h00FE, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
`endif

        // Random frames with gaps
        for (int n = 0; n < 10; n++)
            send_frame(16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

        // Fully random valid/clr traffic, including overruns and flag clears
        for (int n = 0; n < 400; n++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'b1);

        idle_until_ready();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sb_drain", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
